ddr3_req_queue: RTL and testbench

Request queue and issue sequencer upstream of the DDR3 controller's CPU-side port. It buffers host read and write requests in a small FIFO. Requests are presented to the controller one at a time, as single-cycle valid pulses, and only while the controller reports ready. Read data returns to the host with the originating address; write completions return as a done pulse.

---
 rtl/ddr3_req_queue_pkg.sv | 25 ++
 rtl/ddr3_req_fifo.sv | 48 ++++
 rtl/ddr3_req_queue.sv | 156 +++++++++++++++
 tb/tb_ddr3_req_queue.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_req_queue_pkg.sv
// Shared types and widths for the DDR3 host request queue and its FIFO.
package ddr3_req_queue_pkg;

  localparam int DDR3_ADDR_W = 29;
  localparam int DDR3_DATA_W = 64;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ddr3_cmd_e;

  typedef struct packed {
    ddr3_cmd_e               cmd;
    logic [DDR3_ADDR_W-1:0]  addr;
    logic [DDR3_DATA_W-1:0]  wdata;
  } ddr3_req_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_ISSUE,
    SEQ_WAIT_BUSY,
    SEQ_WAIT_DONE
  } req_seq_e;

endpackage

// File: rtl/ddr3_req_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit so full and
// empty are told apart without a separate occupancy counter.
module ddr3_req_fifo
  import ddr3_req_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_push,
  input  ddr3_req_t i_data,
  input  logic      i_pop,
  output logic      o_full,
  output logic      o_empty,
  output ddr3_req_t o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] r_wrPtr;
  logic [AW:0] r_rdPtr;
  ddr3_req_t   r_mem [DEPTH];
  logic        w_doPush;
  logic        w_doPop;

  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty;
  assign o_head   = r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_ONE;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge i_clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/ddr3_req_queue.sv
// Host request queue and one-at-a-time issue sequencer for the DDR3 CPU port.
// Optional watchdog enabled by defining DDR3_REQ_WATCHDOG_EN.
module ddr3_req_queue
  import ddr3_req_queue_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   i_cpu_ck,
  input  logic                   i_cpu_reset,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_cmd,
  input  logic [DDR3_ADDR_W-1:0] i_req_addr,
  input  logic [DDR3_DATA_W-1:0] i_req_wdata,
  output logic                   o_rsp_valid,
  output logic [DDR3_DATA_W-1:0] o_rsp_rdata,
  output logic [DDR3_ADDR_W-1:0] o_rsp_addr,
  output logic                   o_wr_done,
  output logic                   o_err,
  output logic                   o_ctl_valid,
  output logic                   o_ctl_cmd,
  output logic [DDR3_ADDR_W-1:0] o_ctl_addr,
  output logic [DDR3_DATA_W-1:0] o_ctl_wr_data,
  input  logic                   i_ctl_data_rdy,
  input  logic [DDR3_DATA_W-1:0] i_ctl_rd_data,
  input  logic                   i_ctl_rd_data_valid
);

  ddr3_req_t              w_pushData;
  ddr3_req_t              w_head;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_timeout;

  req_seq_e               r_state;
  logic                   r_ctlValid;
  ddr3_cmd_e              r_ctlCmd;
  logic [DDR3_ADDR_W-1:0] r_ctlAddr;
  logic [DDR3_DATA_W-1:0] r_ctlWrData;
  logic                   r_rdFlag;
  logic                   r_rspValid;
  logic [DDR3_DATA_W-1:0] r_rspData;
  logic [DDR3_ADDR_W-1:0] r_rspAddr;
  logic                   r_wrDone;

  assign w_pushData = '{cmd: ddr3_cmd_e'(i_req_cmd), addr: i_req_addr, wdata: i_req_wdata};
  assign w_pop      = (r_state == SEQ_IDLE) && !w_empty && i_ctl_data_rdy;

  ddr3_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_cpu_ck),
    .i_rst   (i_cpu_reset),
    .i_push  (i_req_valid),
    .i_data  (w_pushData),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

`ifdef DDR3_REQ_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wdCnt;
  logic             r_err;
  logic             w_waiting;

  assign w_waiting = (r_state == SEQ_WAIT_BUSY) || (r_state == SEQ_WAIT_DONE);
  assign w_timeout = w_waiting && (r_wdCnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign o_err     = r_err;

  always_ff @(posedge i_cpu_ck or posedge i_cpu_reset) begin
    if (i_cpu_reset) begin
      r_wdCnt <= '0;
      r_err   <= 1'b0;
    end else begin
      r_wdCnt <= (!w_waiting || w_timeout) ? '0 : r_wdCnt + 1'b1;
      if (w_timeout) r_err <= 1'b1;
    end
  end
`else
  // Constant false for any legal limit; the watchdog is simply absent.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
  assign o_err     = 1'b0;
`endif

  always_ff @(posedge i_cpu_ck or posedge i_cpu_reset) begin
    if (i_cpu_reset) begin
      r_state     <= SEQ_IDLE;
      r_ctlValid  <= 1'b0;
      r_ctlCmd    <= READ;
      r_ctlAddr   <= '0;
      r_ctlWrData <= '0;
      r_rdFlag    <= 1'b0;
      r_rspValid  <= 1'b0;
      r_rspData   <= '0;
      r_rspAddr   <= '0;
      r_wrDone    <= 1'b0;
    end else begin
      r_ctlValid <= 1'b0;
      r_rspValid <= 1'b0;
      r_wrDone   <= 1'b0;
      case (r_state)
        SEQ_IDLE: begin
          if (w_pop) begin
            r_ctlCmd    <= w_head.cmd;
            r_ctlAddr   <= w_head.addr;
            r_ctlWrData <= w_head.wdata;
            r_rdFlag    <= 1'b0;
            r_ctlValid  <= 1'b1;
            r_state     <= SEQ_ISSUE;
          end
        end
        SEQ_ISSUE: r_state <= SEQ_WAIT_BUSY;
        SEQ_WAIT_BUSY: begin
          if (!i_ctl_data_rdy) r_state <= SEQ_WAIT_DONE;
        end
        SEQ_WAIT_DONE: begin
          if (r_ctlCmd == WRITE) begin
            if (i_ctl_data_rdy) begin
              r_wrDone <= 1'b1;
              r_state  <= SEQ_IDLE;
            end
          end else begin
            // Only the first data beat is returned; the flag guards repeats.
            if (i_ctl_rd_data_valid && !r_rdFlag) begin
              r_rspValid <= 1'b1;
              r_rspData  <= i_ctl_rd_data;
              r_rspAddr  <= r_ctlAddr;
              r_rdFlag   <= 1'b1;
            end
            if (i_ctl_data_rdy && (r_rdFlag || i_ctl_rd_data_valid)) r_state <= SEQ_IDLE;
          end
        end
        default: r_state <= SEQ_IDLE;
      endcase
      if (w_timeout) begin
        r_rspValid <= 1'b0;
        r_wrDone   <= 1'b0;
        r_state    <= SEQ_IDLE;
      end
    end
  end

  assign o_req_ready   = ~w_full;
  assign o_ctl_valid   = r_ctlValid;
  assign o_ctl_cmd     = r_ctlCmd;
  assign o_ctl_addr    = r_ctlAddr;
  assign o_ctl_wr_data = r_ctlWrData;
  assign o_rsp_valid   = r_rspValid;
  assign o_rsp_rdata   = r_rspData;
  assign o_rsp_addr    = r_rspAddr;
  assign o_wr_done     = r_wrDone;

endmodule

// File: tb/tb_ddr3_req_queue.sv
// Scoreboard bench for ddr3_req_queue: a behavioural controller/memory model
// answers issued requests, and monitors compare issue and response order.
module tb_ddr3_req_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_cmd = 1'b0;
  logic [28:0] i_req_addr = '0;
  logic [63:0] i_req_wdata = '0;
  logic        o_rsp_valid;
  logic [63:0] o_rsp_rdata;
  logic [28:0] o_rsp_addr;
  logic        o_wr_done;
  logic        o_err;
  logic        o_ctl_valid;
  logic        o_ctl_cmd;
  logic [28:0] o_ctl_addr;
  logic [63:0] o_ctl_wr_data;
  logic        i_ctl_data_rdy;
  logic [63:0] i_ctl_rd_data;
  logic        i_ctl_rd_data_valid;

  always #5 clk = ~clk;

  ddr3_req_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(64)) dut (
    .i_cpu_ck            (clk),
    .i_cpu_reset         (rst),
    .i_req_valid         (i_req_valid),
    .o_req_ready         (o_req_ready),
    .i_req_cmd           (i_req_cmd),
    .i_req_addr          (i_req_addr),
    .i_req_wdata         (i_req_wdata),
    .o_rsp_valid         (o_rsp_valid),
    .o_rsp_rdata         (o_rsp_rdata),
    .o_rsp_addr          (o_rsp_addr),
    .o_wr_done           (o_wr_done),
    .o_err               (o_err),
    .o_ctl_valid         (o_ctl_valid),
    .o_ctl_cmd           (o_ctl_cmd),
    .o_ctl_addr          (o_ctl_addr),
    .o_ctl_wr_data       (o_ctl_wr_data),
    .i_ctl_data_rdy      (i_ctl_data_rdy),
    .i_ctl_rd_data       (i_ctl_rd_data),
    .i_ctl_rd_data_valid (i_ctl_rd_data_valid)
  );

  typedef struct {
    bit        cmd;
    bit [28:0] addr;
    bit [63:0] data;
  } exp_t;

  exp_t      issueQ[$];
  exp_t      rspQ[$];
  bit [63:0] ctlMem[bit [28:0]];
  bit [63:0] mdlMem[bit [28:0]];
  int        totalCount = 0;
  int        passCount = 0;
  int        ctlValidCount = 0;
  int        rspCount = 0;
  int        wrDoneCount = 0;
  bit        holdBusy = 0;
  bit        holdReturn = 0;
  bit        prevCtlValid = 0;

  // Content of never-written memory locations, seen identically by both models.
  function automatic bit [63:0] defaultData(bit [28:0] a);
    return {a, 6'h2A, a} ^ 64'h0F0F_3C3C_5A5A_9696;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Must be called at a falling edge; returns at the falling edge after the push edge.
  task automatic applyStimulus(input bit cmd, input bit [28:0] addr, input bit [63:0] wdata,
                               output bit accepted);
    exp_t e;
    i_req_valid = 1'b1;
    i_req_cmd   = cmd;
    i_req_addr  = addr;
    i_req_wdata = wdata;
    #1 accepted = o_req_ready;
    @(posedge clk);
    if (accepted) begin
      e.cmd  = cmd;
      e.addr = addr;
      e.data = wdata;
      issueQ.push_back(e);
      if (cmd) mdlMem[addr] = wdata;
      else e.data = mdlMem.exists(addr) ? mdlMem[addr] : defaultData(addr);
      rspQ.push_back(e);
    end
    @(negedge clk);
    i_req_valid = 1'b0;
  endtask

  task automatic clearModels();
    issueQ.delete();
    rspQ.delete();
    ctlMem.delete();
    mdlMem.delete();
  endtask

  task automatic doReset();
    i_req_valid = 1'b0;
    holdBusy    = 0;
    holdReturn  = 0;
    rst         = 1'b1;
    clearModels();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_reqReady"}, o_req_ready, 1);
    checkOutput({tag, "_ctlValid"}, o_ctl_valid, 0);
    checkOutput({tag, "_ctlFields"}, {o_ctl_cmd, o_ctl_addr, 34'h0}, 0);
    checkOutput({tag, "_ctlWrData"}, o_ctl_wr_data, 0);
    checkOutput({tag, "_rspFields"}, {o_rsp_valid, o_wr_done, o_err, o_rsp_addr, 32'h0}, 0);
    checkOutput({tag, "_rspData"}, o_rsp_rdata, 0);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((issueQ.size() != 0 || rspQ.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput("drainLeft", issueQ.size() + rspQ.size(), 0);
  endtask

  // Behavioural DDR3 controller: ready while idle, busy for a random time
  // after each request, reads answered from its own memory image.
  initial begin
    int        phase = 0;
    int        cnt = 0;
    int        gap = 0;
    int        mode = 0;
    bit        cmd = 0;
    bit [28:0] a = '0;
    bit [63:0] wd = '0;
    i_ctl_data_rdy      = 1'b1;
    i_ctl_rd_data_valid = 1'b0;
    i_ctl_rd_data       = '0;
    forever begin
      @(negedge clk);
      i_ctl_rd_data_valid = 1'b0;
      if (rst) begin
        phase          = 0;
        i_ctl_data_rdy = 1'b1;
      end else begin
        case (phase)
          0: begin
            if (o_ctl_valid) begin
              cmd            = o_ctl_cmd;
              a              = o_ctl_addr;
              wd             = o_ctl_wr_data;
              i_ctl_data_rdy = 1'b0;
              cnt            = $urandom_range(2, 5);
              mode           = $urandom_range(0, 2);
              phase          = 1;
            end else begin
              i_ctl_data_rdy = !holdBusy;
            end
          end
          1: begin
            if (!holdReturn) cnt--;
            if (cnt == 0) begin
              if (cmd) begin
                ctlMem[a]      = wd;
                i_ctl_data_rdy = 1'b1;
                phase          = 0;
              end else begin
                i_ctl_rd_data       = ctlMem.exists(a) ? ctlMem[a] : defaultData(a);
                i_ctl_rd_data_valid = 1'b1;
                if (mode == 0) begin
                  i_ctl_data_rdy = 1'b1;
                  phase          = 0;
                end else begin
                  gap   = mode;
                  phase = 2;
                end
              end
            end
          end
          default: begin
            gap--;
            if (gap == 0) begin
              i_ctl_data_rdy = 1'b1;
              phase          = 0;
            end
          end
        endcase
      end
    end
  end

  // Issue monitor: every controller request must match the next pushed request.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prevCtlValid = 0;
    end else begin
      if (o_ctl_valid) begin
        ctlValidCount++;
        checkOutput("ctlBackToBack", prevCtlValid, 0);
        if (issueQ.size() == 0) begin
          checkOutput("ctlUnexpected", o_ctl_valid, 0);
        end else begin
          e = issueQ.pop_front();
          checkOutput("ctlCmd", o_ctl_cmd, e.cmd);
          checkOutput("ctlAddr", o_ctl_addr, e.addr);
          if (e.cmd) checkOutput("ctlWrData", o_ctl_wr_data, e.data);
        end
      end
      prevCtlValid = o_ctl_valid;
    end
  end

  // Response monitor: read data and write completions in push order.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (o_rsp_valid) begin
        rspCount++;
        if (rspQ.size() == 0) begin
          checkOutput("rspUnexpected", o_rsp_valid, 0);
        end else begin
          e = rspQ.pop_front();
          checkOutput("rspIsRead", e.cmd, 0);
          checkOutput("rspAddr", o_rsp_addr, e.addr);
          checkOutput("rspData", o_rsp_rdata, e.data);
        end
      end
      if (o_wr_done) begin
        wrDoneCount++;
        if (rspQ.size() == 0) begin
          checkOutput("wrDoneUnexpected", o_wr_done, 0);
        end else begin
          e = rspQ.pop_front();
          checkOutput("wrDoneIsWrite", e.cmd, 1);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL globalTimeout: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    bit acc;
    int baseCtl;
    int baseRsp;
    int baseWr;
    int n;

    @(negedge clk);
    @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single read with a known memory value.
    doReset();
    ctlMem[29'h0001_2340] = 64'hDEAD_BEEF_0123_4567;
    mdlMem[29'h0001_2340] = 64'hDEAD_BEEF_0123_4567;
    baseRsp = rspCount;
    applyStimulus(1'b0, 29'h0001_2340, 64'h0, acc);
    checkOutput("readAccepted", acc, 1);
    checkOutput("readPopCycle", o_ctl_valid, 0);
    @(negedge clk);
    checkOutput("readIssueCycle", o_ctl_valid, 1);
    checkOutput("readIssueCmd", o_ctl_cmd, 0);
    @(negedge clk);
    checkOutput("readSinglePulse", o_ctl_valid, 0);
    waitDrain(100);
    checkOutput("readRspCount", rspCount - baseRsp, 1);

    // Single write: one done pulse, no read response.
    baseRsp = rspCount;
    baseWr  = wrDoneCount;
    applyStimulus(1'b1, 29'h0000_0040, 64'hA5A5_A5A5_5A5A_5A5A, acc);
    waitDrain(100);
    checkOutput("writeDoneCount", wrDoneCount - baseWr, 1);
    checkOutput("writeNoRsp", rspCount - baseRsp, 0);

    // Full boundary with the controller held busy.
    doReset();
    holdBusy = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus(i[0], 29'h200 + 29'(i * 8), {32'hF00D_0000, 32'(i)}, acc);
      checkOutput("fullAccept", acc, (i < DEPTH));
      checkOutput("fullReady", o_req_ready, (i < DEPTH - 1));
    end
    baseCtl  = ctlValidCount;
    holdBusy = 0;
    waitDrain(300);
    checkOutput("fullIssueCount", ctlValidCount - baseCtl, DEPTH);

    // Randomised mixed traffic through a small address set (pointer wrap, RAW).
    doReset();
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 29'h100 + 29'($urandom_range(0, 7) * 8),
                    {$urandom, $urandom}, acc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    waitDrain(3000);

    // Reset while a read is outstanding and two more are queued.
    doReset();
    holdReturn = 1;
    applyStimulus(1'b0, 29'h0000_0500, 64'h0, acc);
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 29'h0000_0508, 64'h1111_2222_3333_4444, acc);
    applyStimulus(1'b0, 29'h0000_0510, 64'h0, acc);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 checkResetState("midReset");
    clearModels();
    @(negedge clk);
    @(negedge clk);
    rst        = 1'b0;
    holdReturn = 0;
    baseCtl = ctlValidCount;
    baseRsp = rspCount;
    baseWr  = wrDoneCount;
    repeat (20) @(negedge clk);
    checkOutput("postResetIssues", ctlValidCount - baseCtl, 0);
    checkOutput("postResetRsps", (rspCount - baseRsp) + (wrDoneCount - baseWr), 0);
    checkOutput("postResetReady", o_req_ready, 1);

`ifdef DDR3_REQ_WATCHDOG_EN
    // Controller never returns: the first read is dropped, the second proceeds.
    doReset();
    holdReturn = 1;
    applyStimulus(1'b0, 29'h0000_0300, 64'h0, acc);
    applyStimulus(1'b0, 29'h0000_0308, 64'h0, acc);
    n = 0;
    while (!o_err && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wdErr", o_err, 1);
    checkOutput("wdLatency", n, 65);
    if (rspQ.size() != 0) void'(rspQ.pop_front());
    holdReturn = 0;
    waitDrain(200);
    checkOutput("wdErrSticky", o_err, 1);
`else
    n = 0;
    checkOutput("errTiedLow", o_err, n);
`endif

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
